// File: rtl/ls_cnt_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ls_cnt_seq_pkg : shared states and constants for the test-window sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package ls_cnt_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_LATCH  = 3'd4,
    ST_REPORT = 3'd5
  } seq_state_t;

  localparam logic [1:0] CLK_CTRL_TWO_STAGE = 2'b00;
  localparam logic [1:0] CLK_CTRL_ONE_STAGE = 2'b01;

  localparam int SETTLE_MIN = 2;
  localparam int SETTLE_MAX = 255;

  function automatic int clamp_settle(input int cyc);
    if (cyc < SETTLE_MIN) return SETTLE_MIN;
    if (cyc > SETTLE_MAX) return SETTLE_MAX;
    return cyc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ls_seq_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ls_seq_timer : loadable saturating down-counter with registered done flag
// Rev 1.0
// ----------------------------------------------------------------------------
module ls_seq_timer
  import ls_cnt_seq_pkg::*;
#(
  parameter int WIN_W = 32
) (
  input  logic             CLK,
  input  logic             RST_PER,
  input  logic             load,
  input  logic [WIN_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  localparam logic [WIN_W-1:0] c_ONE = WIN_W'(1);
  localparam logic [WIN_W-1:0] c_TWO = WIN_W'(2);

  logic [WIN_W-1:0] r_cnt;
  logic             r_done;

  // done is high during the final counted cycle, so a load value of N
  // yields exactly N cycles before the owner moves on.
  always_ff @(posedge CLK or posedge RST_PER) begin
    if (RST_PER) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (load) begin
      r_cnt  <= load_val;
      r_done <= (load_val == c_ONE);
    end else if (en) begin
      if (r_cnt != '0) r_cnt <= r_cnt - c_ONE;
      r_done <= (r_cnt == c_TWO);
    end
  end

  assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/ls_cnt_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ls_cnt_seq : test-window sequencer for the DICE error-counter datapath
// Optional auto-repeat enabled by defining LS_CNT_SEQ_AUTORPT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module ls_cnt_seq
  import ls_cnt_seq_pkg::*;
#(
  parameter int WIN_W      = 32,
  parameter int SETTLE_CYC = 4,
  parameter int ID_W       = 8
) (
  input  logic             CLK,
  input  logic             RST_PER,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       CFG_CLK_CTRL,
  input  logic [WIN_W-1:0] CFG_WINDOW,
`ifdef LS_CNT_SEQ_AUTORPT_EN
  input  logic             CFG_REPEAT,
`endif
  input  logic [31:0]      ERR_CNT_IN,
  output logic             CNT_CLR,
  output logic             RPG_RST,
  output logic             CMP_EN,
  output logic [1:0]       CLK_CTRL,
  output logic             BUSY,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [31:0]      RES_ERR,
  output logic [ID_W-1:0]  RES_ID
);

  localparam logic [WIN_W-1:0] c_SETTLE_LD = WIN_W'(clamp_settle(SETTLE_CYC));
  localparam logic [WIN_W-1:0] c_WIN_MIN   = WIN_W'(1);
  localparam logic [ID_W-1:0]  c_ID_ONE    = ID_W'(1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;

  logic [WIN_W-1:0] r_cfg_window;
  logic [1:0]       r_cfg_clk_ctrl;
  logic [1:0]       r_clk_ctrl;
  logic [31:0]      r_res_err;
  logic [ID_W-1:0]  r_res_id;

  logic             w_start_acc;
  logic             w_enter_clear;
  logic             w_capture;
  logic             w_handshake;
  logic             w_repeat;
  logic             w_tmr_load;
  logic [WIN_W-1:0] w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_done;
  logic [WIN_W-1:0] w_win_ld;

`ifdef LS_CNT_SEQ_AUTORPT_EN
  logic r_cfg_repeat;

  always_ff @(posedge CLK or posedge RST_PER) begin
    if (RST_PER)          r_cfg_repeat <= 1'b0;
    else if (w_start_acc) r_cfg_repeat <= CFG_REPEAT;
  end

  assign w_repeat = r_cfg_repeat;
`else
  assign w_repeat = 1'b0;
`endif

  // A zero-length window still runs one comparison cycle.
  assign w_win_ld = (r_cfg_window == '0) ? c_WIN_MIN : r_cfg_window;

  ls_seq_timer #(
    .WIN_W    (WIN_W)
  ) u_timer (
    .CLK      (CLK),
    .RST_PER  (RST_PER),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .en       (w_tmr_en),
    .done     (w_tmr_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START && !ABORT) begin
          w_start_acc = 1'b1;
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_SETTLE_LD;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmr_done) begin
          w_tmr_load  = 1'b1;
          w_tmr_val   = w_win_ld;
          w_state_nxt = ST_RUN;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_en = 1'b1;
          if (w_tmr_done) w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else if (RES_READY) begin
          w_handshake = 1'b1;
          w_state_nxt = w_repeat ? ST_CLEAR : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_clear = w_start_acc | (w_handshake & w_repeat);

  always_ff @(posedge CLK or posedge RST_PER) begin
    if (RST_PER) begin
      r_state        <= ST_IDLE;
      r_cfg_window   <= '0;
      r_cfg_clk_ctrl <= '0;
      r_clk_ctrl     <= '0;
      r_res_err      <= '0;
      r_res_id       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_cfg_window   <= CFG_WINDOW;
        r_cfg_clk_ctrl <= CFG_CLK_CTRL;
      end
      // On a fresh start the latch and the output copy update on the same edge.
      if (w_enter_clear) r_clk_ctrl <= w_start_acc ? CFG_CLK_CTRL : r_cfg_clk_ctrl;
      if (w_capture)     r_res_err  <= ERR_CNT_IN;
      if (w_handshake)   r_res_id   <= r_res_id + c_ID_ONE;
    end
  end

  assign CNT_CLR   = (r_state == ST_CLEAR);
  assign RPG_RST   = (r_state == ST_CLEAR);
  assign CMP_EN    = (r_state == ST_RUN);
  assign BUSY      = (r_state != ST_IDLE);
  assign RES_VALID = (r_state == ST_REPORT);
  assign CLK_CTRL  = r_clk_ctrl;
  assign RES_ERR   = r_res_err;
  assign RES_ID    = r_res_id;

endmodule
`default_nettype wire

// File: tb/tb_ls_cnt_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ls_cnt_seq : randomized self-checking bench for ls_cnt_seq
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ls_cnt_seq;
  import ls_cnt_seq_pkg::*;

  localparam int WIN_W      = 32;
  localparam int SETTLE_CYC = 4;
  localparam int ID_W       = 8;
  localparam int SETTLE_EFF = (SETTLE_CYC < 2) ? 2 : ((SETTLE_CYC > 255) ? 255 : SETTLE_CYC);

  logic             CLK = 1'b0;
  logic             RST_PER = 1'b1;
  logic             START = 1'b0;
  logic             ABORT = 1'b0;
  logic [1:0]       CFG_CLK_CTRL = '0;
  logic [WIN_W-1:0] CFG_WINDOW = '0;
`ifdef LS_CNT_SEQ_AUTORPT_EN
  logic             CFG_REPEAT = 1'b0;
`endif
  logic [31:0]      ERR_CNT_IN;
  logic             CNT_CLR, RPG_RST, CMP_EN, BUSY, RES_VALID;
  logic [1:0]       CLK_CTRL;
  logic             RES_READY = 1'b0;
  logic [31:0]      RES_ERR;
  logic [ID_W-1:0]  RES_ID;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [ID_W-1:0]  exp_id = '0;

  // Error-counter datapath stand-in: cleared by CNT_CLR, counts injected errors.
  logic [31:0]      err_ctr;
  logic [31:0]      err_offset = '0;
  logic             inj_now = 1'b0;

  always @(posedge CLK or posedge RST_PER) begin
    if (RST_PER)                err_ctr <= '0;
    else if (CNT_CLR)           err_ctr <= '0;
    else if (CMP_EN && inj_now) err_ctr <= err_ctr + 32'd1;
  end

  assign ERR_CNT_IN = err_ctr + err_offset;

  always #5 CLK = ~CLK;

  ls_cnt_seq #(
    .WIN_W        (WIN_W),
    .SETTLE_CYC   (SETTLE_CYC),
    .ID_W         (ID_W)
  ) dut (
    .CLK          (CLK),
    .RST_PER      (RST_PER),
    .START        (START),
    .ABORT        (ABORT),
    .CFG_CLK_CTRL (CFG_CLK_CTRL),
    .CFG_WINDOW   (CFG_WINDOW),
`ifdef LS_CNT_SEQ_AUTORPT_EN
    .CFG_REPEAT   (CFG_REPEAT),
`endif
    .ERR_CNT_IN   (ERR_CNT_IN),
    .CNT_CLR      (CNT_CLR),
    .RPG_RST      (RPG_RST),
    .CMP_EN       (CMP_EN),
    .CLK_CTRL     (CLK_CTRL),
    .BUSY         (BUSY),
    .RES_VALID    (RES_VALID),
    .RES_READY    (RES_READY),
    .RES_ERR      (RES_ERR),
    .RES_ID       (RES_ID)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({CNT_CLR, RPG_RST, CMP_EN, CLK_CTRL, BUSY, RES_VALID, RES_ERR, RES_ID} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got clr=%b rpg=%b cmp=%b cc=%b busy=%b vld=%b err=%0d id=%0d want all 0",
               CNT_CLR, RPG_RST, CMP_EN, CLK_CTRL, BUSY, RES_VALID, RES_ERR, RES_ID);
    end
    RST_PER = 1'b0;
    tick();
  endtask

  // One complete run: checks pulse widths, window length, latency, snapshot
  // and handshake against the rules; restart_at>0 fires a stray START in RUN.
  task automatic run_and_check(input logic [31:0] win, input logic [1:0] cc, input int ready_delay,
                               input int inj_pct, input logic [31:0] base, input int restart_at,
                               input string name);
    int          edges, clr, rpg, cmp, wexp, lat_exp;
    logic [31:0] exp_err;
    bit          cc_ok, seen, stable;
    wexp       = (win == 0) ? 1 : int'(win);
    lat_exp    = 2 + SETTLE_EFF + wexp + 1;
    exp_err    = base;
    err_offset = base;
    CFG_WINDOW   = win;
    CFG_CLK_CTRL = cc;
    START        = 1'b1;
    tick();
    START        = 1'b0;
    CFG_WINDOW   = $urandom;
    CFG_CLK_CTRL = 2'($urandom);
    edges = 1; clr = 0; rpg = 0; cmp = 0; cc_ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (RES_VALID) begin
        seen = 1'b1;
        break;
      end
      inj_now = ($urandom_range(99) < inj_pct);
      clr += int'(CNT_CLR);
      rpg += int'(RPG_RST);
      if (CMP_EN) begin
        cmp++;
        if (inj_now) exp_err++;
        if (CLK_CTRL !== cc) cc_ok = 1'b0;
        if (cmp == restart_at) begin
          START      = 1'b1;
          CFG_WINDOW = win + 32'd5;
        end
      end
      tick();
      START = 1'b0;
      edges++;
    end
    inj_now = 1'b0;

    n_checks++;
    if (!seen || edges != lat_exp) begin
      n_errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, edges, seen, lat_exp);
    end
    n_checks++;
    if (clr != 1 || rpg != 1) begin
      n_errors++;
      $display("FAIL %s clear_pulse: got clr=%0d rpg=%0d want 1 1", name, clr, rpg);
    end
    n_checks++;
    if (cmp != wexp) begin
      n_errors++;
      $display("FAIL %s cmp_en_cycles: got %0d want %0d", name, cmp, wexp);
    end
    n_checks++;
    if (!cc_ok || CLK_CTRL !== cc) begin
      n_errors++;
      $display("FAIL %s clk_ctrl: got %b want %b", name, CLK_CTRL, cc);
    end
    n_checks++;
    if (RES_ERR !== exp_err || RES_ID !== exp_id || BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL %s result: got err=%0d id=%0d busy=%b want err=%0d id=%0d busy=1",
               name, RES_ERR, RES_ID, BUSY, exp_err, exp_id);
    end

    stable = 1'b1;
    for (int i = 0; i < ready_delay; i++) begin
      err_offset = $urandom;
      tick();
      if (RES_VALID !== 1'b1 || RES_ERR !== exp_err || RES_ID !== exp_id) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin
      n_errors++;
      $display("FAIL %s hold: got vld=%b err=%0d id=%0d want vld=1 err=%0d id=%0d",
               name, RES_VALID, RES_ERR, RES_ID, exp_err, exp_id);
    end

    RES_READY = 1'b1;
    tick();
    RES_READY  = 1'b0;
    err_offset = '0;
    n_checks++;
    if (RES_VALID !== 1'b0 || BUSY !== 1'b0 || RES_ID !== ID_W'(exp_id + 1)) begin
      n_errors++;
      $display("FAIL %s handshake: got vld=%b busy=%b id=%0d want vld=0 busy=0 id=%0d",
               name, RES_VALID, BUSY, RES_ID, ID_W'(exp_id + 1));
    end
    exp_id = ID_W'(exp_id + 1);
  endtask

  task automatic test_basic();
    run_and_check(32'd10, CLK_CTRL_TWO_STAGE, 0, 0, 32'd7, 0, "basic");
  endtask

  task automatic test_window_zero();
    run_and_check(32'd0, CLK_CTRL_ONE_STAGE, 1, 100, 32'd0, 0, "window_zero");
  endtask

  task automatic test_backpressure();
    run_and_check(32'd6, 2'b10, 20, 50, 32'd0, 0, "backpressure");
  endtask

  task automatic test_start_during_run();
    run_and_check(32'd10, 2'b11, 1, 30, 32'd0, 4, "start_in_run");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++)
      run_and_check(32'($urandom_range(0, 20)), 2'($urandom), $urandom_range(0, 4), 40, 32'd0, 0, "random");
  endtask

  task automatic test_abort();
    int cmp;
    bit aborted, saw;
    CFG_WINDOW = 32'd10;
    START      = 1'b1;
    tick();
    START   = 1'b0;
    cmp     = 0;
    aborted = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (CMP_EN) cmp++;
      if (cmp == 3) begin
        ABORT = 1'b1;
        tick();
        ABORT   = 1'b0;
        aborted = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!aborted || CMP_EN !== 1'b0 || BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_run: got aborted=%0d cmp=%b busy=%b want 1 0 0", aborted, CMP_EN, BUSY);
    end
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (RES_VALID) saw = 1'b1;
      tick();
    end
    n_checks++;
    if (saw || RES_ID !== exp_id) begin
      n_errors++;
      $display("FAIL abort_no_result: got vld_seen=%0d id=%0d want 0 %0d", saw, RES_ID, exp_id);
    end
  endtask

  task automatic test_start_abort_same();
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    n_checks++;
    if (BUSY !== 1'b0 || CNT_CLR !== 1'b0) begin
      n_errors++;
      $display("FAIL start_abort_idle: got busy=%b clr=%b want 0 0", BUSY, CNT_CLR);
    end
    tick();
    tick();
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL start_abort_later: got busy=%b want 0", BUSY);
    end
  endtask

  task automatic test_reset_mid();
    CFG_WINDOW   = 32'd8;
    CFG_CLK_CTRL = 2'b11;
    START        = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    n_checks++;
    if (BUSY !== 1'b1 || CMP_EN !== 1'b0 || CLK_CTRL !== 2'b11) begin
      n_errors++;
      $display("FAIL settle_state: got busy=%b cmp=%b cc=%b want 1 0 11", BUSY, CMP_EN, CLK_CTRL);
    end
    #2 RST_PER = 1'b1;
    #1;
    n_checks++;
    if ({CNT_CLR, RPG_RST, CMP_EN, CLK_CTRL, BUSY, RES_VALID, RES_ERR, RES_ID} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got clr=%b rpg=%b cmp=%b cc=%b busy=%b vld=%b err=%0d id=%0d want all 0",
               CNT_CLR, RPG_RST, CMP_EN, CLK_CTRL, BUSY, RES_VALID, RES_ERR, RES_ID);
    end
    #3 RST_PER = 1'b0;
    exp_id = '0;
    tick();
    run_and_check(32'd3, CLK_CTRL_ONE_STAGE, 2, 50, 32'd0, 0, "after_reset");
  endtask

`ifdef LS_CNT_SEQ_AUTORPT_EN
  task automatic test_autorepeat();
    bit seen, saw;
    CFG_REPEAT = 1'b1;
    CFG_WINDOW = 32'd5;
    RES_READY  = 1'b1;
    START      = 1'b1;
    tick();
    START      = 1'b0;
    CFG_REPEAT = 1'b0;
    for (int r = 0; r < 3; r++) begin
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (RES_VALID) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      n_checks++;
      if (!seen || RES_ID !== exp_id) begin
        n_errors++;
        $display("FAIL autorpt_result: got seen=%0d id=%0d want 1 %0d", seen, RES_ID, exp_id);
      end
      tick();
      n_checks++;
      if (BUSY !== 1'b1 || CNT_CLR !== 1'b1 || RES_ID !== ID_W'(exp_id + 1)) begin
        n_errors++;
        $display("FAIL autorpt_restart: got busy=%b clr=%b id=%0d want 1 1 %0d",
                 BUSY, CNT_CLR, RES_ID, ID_W'(exp_id + 1));
      end
      exp_id = ID_W'(exp_id + 1);
    end
    tick();
    tick();
    ABORT = 1'b1;
    tick();
    ABORT     = 1'b0;
    RES_READY = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (RES_VALID || BUSY) saw = 1'b1;
      tick();
    end
    n_checks++;
    if (saw || RES_ID !== exp_id) begin
      n_errors++;
      $display("FAIL autorpt_abort: got activity=%0d id=%0d want 0 %0d", saw, RES_ID, exp_id);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_abort();
    test_basic();
    test_window_zero();
    test_backpressure();
    test_start_abort_same();
    test_start_during_run();
    test_random();
    test_reset_mid();
`ifdef LS_CNT_SEQ_AUTORPT_EN
    test_autorepeat();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ls_cnt_seq.md
Name: ls_cnt_seq

Overview:
- Test-window sequencer for the DICE latch/shift-register error-counter datapath.
- Per run, it clears the error counter, resets the pattern generator, and programs the comparator sample-delay select.
- It masks comparisons while the two-stage sampler fills, then enables counting for a programmed window and snapshots the count.
- It presents each result to the host readout over a valid/ready handshake. Sits between the host command/UART register block and the per-DUT error-counter instance.

Parameters:
- WIN_W, 32, width of the run-window length in CLK cycles
- SETTLE_CYC, 4, masked cycles between counter clear and comparison enable (covers sampler pipeline fill); legal range 2..255
- ID_W, 8, width of the run identifier

Ports:
- CLK  in  1  test clock (same as the counter datapath clock)
- RST_PER  in  1  reset, asynchronous, active-high
- START  in  1  single-cycle pulse; begins a run when the block is idle
- ABORT  in  1  single-cycle pulse; cancels the current run
- CFG_CLK_CTRL  in  2  sample-delay select for the datapath; latched at START
- CFG_WINDOW  in  WIN_W  comparison window length in cycles; latched at START
- ERR_CNT_IN  in  32  error count from the counter datapath
- CNT_CLR  out  1  counter clear request; drives the counter reset OR-term
- RPG_RST  out  1  pattern-generator reset
- CMP_EN  out  1  comparison enable; gates the counter increment
- CLK_CTRL  out  2  registered copy of the latched CFG_CLK_CTRL
- BUSY  out  1  high in every state except IDLE
- RES_VALID  out  1  result available
- RES_READY  in  1  host accepts the result
- RES_ERR  out  32  snapshot of the error count
- RES_ID  out  ID_W  run identifier of the current result

Behaviour:
- Reset values: all outputs 0; RES_ID 0; FSM in IDLE; latched config 0.
- FSM states: IDLE, CLEAR, SETTLE, RUN, LATCH, REPORT.
- IDLE:
  - START=1 and ABORT=0 latches CFG_CLK_CTRL and CFG_WINDOW; next state CLEAR.
  - START with ABORT in the same cycle: ABORT wins; the block stays in IDLE.
  - START outside IDLE is ignored.
- CLEAR: exactly 1 cycle with CNT_CLR=1 and RPG_RST=1. CLK_CTRL takes the latched value on CLEAR entry. Next state SETTLE.
- SETTLE:
  - CMP_EN=0 for exactly SETTLE_CYC cycles, then RUN.
  - SETTLE_CYC values outside 2..255 are clamped to that range at elaboration.
- RUN:
  - CMP_EN=1 for exactly max(CFG_WINDOW,1) cycles; a window of 0 is treated as 1.
  - The window down-counter loads on SETTLE exit and never wraps.
  - Next state LATCH.
- LATCH:
  - CMP_EN=0. Waits 1 cycle so the last increment registers in the counter, then captures ERR_CNT_IN into RES_ERR.
  - RES_VALID rises on REPORT entry.
- REPORT:
  - RES_VALID is held high and RES_ERR/RES_ID are held stable until RES_VALID & RES_READY.
  - The handshake cycle clears RES_VALID and increments RES_ID, modulo 2^ID_W (wraps at 2^ID_W-1 to 0).
  - Next state IDLE.
- ABORT in CLEAR/SETTLE/RUN/LATCH: next state IDLE; CMP_EN=0 from the next cycle; no result; RES_ID unchanged.
- ABORT in REPORT: RES_VALID drops next cycle; RES_ID unchanged.
- Total latency: START to RES_VALID = 1 + 1 + SETTLE_CYC + max(W,1) + 1 cycles.
- RST_PER mid-run: immediate return to the reset values. The counter is not cleared by this block; it is cleared by RST_PER directly.

Optional Feature:
- Macro: LS_CNT_SEQ_AUTORPT_EN.
- When defined:
  - Adds input CFG_REPEAT (1 bit), latched at START.
  - On the REPORT handshake with latched CFG_REPEAT=1, next state is CLEAR instead of IDLE.
  - The latched config is reused and BUSY stays high.
  - ABORT terminates repetition.
- When undefined: no CFG_REPEAT port; REPORT always returns to IDLE.

Decomposition:
- Package ls_cnt_seq_pkg holds:
  - state enum/encoding (3-bit) for IDLE..REPORT
  - CLK_CTRL constants: 2'b00 = two-stage sample, others = one-stage
  - SETTLE_MIN=2 and SETTLE_MAX=255
- Sub-module ls_seq_timer: loadable WIN_W-bit down-counter with load, enable, and a registered done flag. Used for both SETTLE and RUN.

Test Plan:
- SETTLE_CYC=4, CFG_WINDOW=10, RES_READY=1, ERR_CNT_IN=7 → CNT_CLR and RPG_RST pulse 1 cycle; CMP_EN high exactly 10 cycles; RES_VALID 17 cycles after START; RES_ERR=7; RES_ID=0, then 1 after the handshake.
- CFG_WINDOW=0 → CMP_EN high exactly 1 cycle; normal report.
- RES_READY held 0 for 20 cycles, ERR_CNT_IN changing → RES_VALID stays high; RES_ERR and RES_ID stable until RES_READY=1; FSM returns to IDLE the cycle after the handshake.
- ABORT on the 3rd RUN cycle → CMP_EN=0 next cycle; BUSY=0; RES_VALID never asserted; a following START produces RES_ID=0.
- START and ABORT in the same cycle in IDLE → no state change. START during RUN → ignored; window length unchanged.
- RST_PER asserted mid-SETTLE → all outputs 0 asynchronously. With LS_CNT_SEQ_AUTORPT_EN, CFG_REPEAT=1 → three back-to-back runs with RES_ID 0,1,2; ABORT stops further runs.
